// File: rtl/muldiv_unit_if.sv
// Request/response bundle between operand select, the mul/div unit and writeback.
// op encoding: 0 MUL, 1 MULW, 2 DIV, 3 DIVW, 4 DIVU, 5 DIVUW, 6 MOD, 7 MODW, 8 MODU, 9 MODUW.
interface muldiv_unit_if #(
  parameter int unsigned XLEN = 64
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      op;
  logic [XLEN-1:0] srca;
  logic [XLEN-1:0] srcb;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  modport master (
    output flush, in_valid, op, srca, srcb, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  flush, in_valid, op, srca, srcb, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle, with
// valid/ready handshake on both sides and a synchronous flush. Only XLEN=64 is supported.
module muldiv_unit #(
  parameter int unsigned XLEN = 64
) (
  input  logic         clk,
  input  logic         resetn,
  muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  typedef enum logic [3:0] {
    OP_MUL   = 4'd0,
    OP_MULW  = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVW  = 4'd3,
    OP_DIVU  = 4'd4,
    OP_DIVUW = 4'd5,
    OP_MOD   = 4'd6,
    OP_MODW  = 4'd7,
    OP_MODU  = 4'd8,
    OP_MODUW = 4'd9
  } decode_op_t;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  state_t          state_q;
  logic [6:0]      cnt_q;
  logic [XLEN-1:0] acc_q, opa_q, opb_q, result_q;
  logic            is_mul_q, is_w_q, is_rem_q, neg_q, out_valid_q;

  // Accept-side decode and operand preparation
  decode_op_t      op_in;
  logic            dec_valid, dec_mul, dec_w, dec_signed, dec_rem;
  logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs, min_val, spec_res;
  logic            a_neg, b_neg, b_zero, ovf, special;

  assign op_in = decode_op_t'(bus.op);

  always_comb begin
    dec_valid  = 1'b1;
    dec_mul    = 1'b0;
    dec_w      = 1'b0;
    dec_signed = 1'b0;
    dec_rem    = 1'b0;
    case (op_in)
      OP_MUL:   dec_mul = 1'b1;
      OP_MULW:  begin dec_mul = 1'b1; dec_w = 1'b1; end
      OP_DIV:   dec_signed = 1'b1;
      OP_DIVW:  begin dec_signed = 1'b1; dec_w = 1'b1; end
      OP_DIVU:  ;
      OP_DIVUW: dec_w = 1'b1;
      OP_MOD:   begin dec_rem = 1'b1; dec_signed = 1'b1; end
      OP_MODW:  begin dec_rem = 1'b1; dec_signed = 1'b1; dec_w = 1'b1; end
      OP_MODU:  dec_rem = 1'b1;
      OP_MODUW: begin dec_rem = 1'b1; dec_w = 1'b1; end
      default:  dec_valid = 1'b0;
    endcase
  end

  always_comb begin
    if (dec_w) begin
      a_ext = dec_signed ? sext32(bus.srca[31:0]) : {{(XLEN-32){1'b0}}, bus.srca[31:0]};
      b_ext = dec_signed ? sext32(bus.srcb[31:0]) : {{(XLEN-32){1'b0}}, bus.srcb[31:0]};
    end else begin
      a_ext = bus.srca;
      b_ext = bus.srcb;
    end
    a_neg   = dec_signed & a_ext[XLEN-1];
    b_neg   = dec_signed & b_ext[XLEN-1];
    a_abs   = a_neg ? ('0 - a_ext) : a_ext;
    b_abs   = b_neg ? ('0 - b_ext) : b_ext;
    min_val = dec_w ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
    b_zero  = (b_ext == '0);
    ovf     = dec_signed & (a_ext == min_val) & (b_ext == '1);
    special = ~dec_valid | (~dec_mul & (b_zero | ovf));
    if (!dec_valid) begin
      spec_res = '0;
    end else if (b_zero) begin
      // MODUW keeps a zero-extended dividend internally; the result is still sign-extended
      spec_res = dec_rem ? (dec_w ? sext32(a_ext[31:0]) : a_ext) : '1;
    end else begin
      spec_res = dec_rem ? '0 : min_val;
    end
  end

  // One iteration of the running operation, plus the value to publish on the final one
  logic [XLEN:0]   rem_sh;
  logic            qbit;
  logic [XLEN-1:0] acc_d, opa_d, opb_d, raw, res_d;

  always_comb begin
    acc_d  = acc_q;
    opa_d  = opa_q;
    opb_d  = opb_q;
    rem_sh = '0;
    qbit   = 1'b0;
    if (is_mul_q) begin
      acc_d = acc_q + (opb_q[0] ? opa_q : '0);
      opa_d = opa_q << 1;
      opb_d = opb_q >> 1;
    end else begin
      rem_sh = {acc_q, opa_q[XLEN-1]};
      qbit   = (rem_sh >= {1'b0, opb_q});
      // The true difference is below the divisor, so the low XLEN bits are exact
      acc_d  = qbit ? (rem_sh[XLEN-1:0] - opb_q) : rem_sh[XLEN-1:0];
      opa_d  = {opa_q[XLEN-2:0], qbit};
    end
    raw = (is_mul_q || is_rem_q) ? acc_d : opa_d;
    if (!is_mul_q && neg_q) begin
      raw = '0 - raw;
    end
    res_d = is_w_q ? sext32(raw[31:0]) : raw;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      result_q    <= '0;
      is_mul_q    <= 1'b0;
      is_w_q      <= 1'b0;
      is_rem_q    <= 1'b0;
      neg_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (bus.flush) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            is_mul_q <= dec_mul;
            is_w_q   <= dec_w;
            is_rem_q <= dec_rem;
            neg_q    <= dec_rem ? a_neg : (a_neg ^ b_neg);
            cnt_q    <= dec_w ? 7'd32 : 7'd64;
            acc_q    <= '0;
            if (dec_mul) begin
              opa_q <= a_ext;
              opb_q <= b_ext;
            end else begin
              // W dividends are pre-aligned to the top so 32 iterations consume them
              opa_q <= dec_w ? {a_abs[31:0], {(XLEN-32){1'b0}}} : a_abs;
              opb_q <= b_abs;
            end
            if (special) begin
              result_q    <= spec_res;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              state_q <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          acc_q <= acc_d;
          opa_q <= opa_d;
          opb_q <= opb_d;
          cnt_q <= cnt_q - 7'd1;
          if (cnt_q == 7'd1) begin
            result_q    <= res_d;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;

endmodule
